// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the matrix-keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int CODE_W   = 4;
    localparam logic [NUM_ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } scan_state_t;

    // Active-low one-hot column drive for a column index.
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [1:0] col);
        return ~(4'b0001 << col);
    endfunction

    // Index of the lowest zero bit; lowest row wins when several are low.
    function automatic logic [1:0] low_zero_idx(input logic [NUM_ROWS-1:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (!pat[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix and key-event signals; master = scanner, slave = keypad/consumer side.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] KEY_ROW;
    logic [NUM_COLS-1:0] KEY_COL;
    logic [CODE_W-1:0]   KEY_CODE;
    logic                KEY_VALID;
    logic                KEY_HELD;

    modport master (
        input  KEY_ROW,
        output KEY_COL,
        output KEY_CODE,
        output KEY_VALID,
        output KEY_HELD
    );

    modport slave (
        output KEY_ROW,
        input  KEY_COL,
        input  KEY_CODE,
        input  KEY_VALID,
        input  KEY_HELD
    );
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-CLK strobe every DIV cycles, first strobe ends on edge DIV after reset.
module scan_tick_gen #(
    parameter int DIV = 250000
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with debounce, column lock and priority encode.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 250000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DLY   = 100,
    parameter int REPEAT_RATE  = 25
) (
    input logic           CLK,
    input logic           RESET,
    keypad_scan_if.master kif
);
    // One width serves every tick counter so the repeat settings size nothing else.
    localparam int MAX_A     = (DEBOUNCE_CNT > REPEAT_DLY) ? DEBOUNCE_CNT : REPEAT_DLY;
    localparam int MAX_TICKS = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    logic                tick;
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_s;
    scan_state_t         state;
    logic [1:0]          col;
    logic [NUM_COLS-1:0] key_col;
    logic [NUM_ROWS-1:0] pattern;
    cnt_t                deb_cnt;
    cnt_t                rel_cnt;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                key_held;
`ifdef KEYPAD_REPEAT_EN
    cnt_t                rep_cnt;
    logic                rep_first;
`endif

    scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .tick  (tick)
    );

    // Rows are asynchronous to CLK; only the second flop is ever used.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_meta <= ROW_IDLE;
            row_s    <= ROW_IDLE;
        end else begin
            row_meta <= kif.KEY_ROW;
            row_s    <= row_meta;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= SCAN;
            col       <= 2'd0;
            key_col   <= 4'b1110;
            pattern   <= ROW_IDLE;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (row_s == ROW_IDLE) begin
                            col     <= col + 2'd1;
                            key_col <= col_drive(col + 2'd1);
                        end else begin
                            pattern <= row_s;
                            deb_cnt <= cnt_t'(1);
                            state   <= DEBOUNCE;
                        end
                    end

                    DEBOUNCE: begin
                        if (row_s == pattern) begin
                            if (int'(deb_cnt) + 1 >= DEBOUNCE_CNT) begin
                                key_code  <= {col, low_zero_idx(pattern)};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                deb_cnt   <= '0;
                                rel_cnt   <= '0;
                                state     <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt   <= '0;
                                rep_first <= 1'b1;
`endif
                            end else begin
                                deb_cnt <= deb_cnt + cnt_t'(1);
                            end
                        end else begin
                            deb_cnt <= '0;
                            col     <= col + 2'd1;
                            key_col <= col_drive(col + 2'd1);
                            state   <= SCAN;
                        end
                    end

                    HELD: begin
                        // Column stays locked here, so other columns are never observed.
                        if (row_s == ROW_IDLE) begin
`ifdef KEYPAD_REPEAT_EN
                            rep_cnt <= '0;
`endif
                            if (int'(rel_cnt) + 1 >= DEBOUNCE_CNT) begin
                                key_held <= 1'b0;
                                rel_cnt  <= '0;
                                col      <= col + 2'd1;
                                key_col  <= col_drive(col + 2'd1);
                                state    <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + cnt_t'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                            if (int'(rep_cnt) + 1 >= (rep_first ? REPEAT_DLY : REPEAT_RATE)) begin
                                key_valid <= 1'b1;
                                rep_cnt   <= '0;
                                rep_first <= 1'b0;
                            end else begin
                                rep_cnt <= rep_cnt + cnt_t'(1);
                            end
`endif
                        end
                    end

                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kif.KEY_COL   = key_col;
    assign kif.KEY_CODE  = key_code;
    assign kif.KEY_VALID = key_valid;
    assign kif.KEY_HELD  = key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: matrix model drives rows, scoreboard queue checks every KEY_VALID.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int RDLY     = 5;
    localparam int RRATE    = 2;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    always #5 CLK = ~CLK;

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEB),
        .REPEAT_DLY   (RDLY),
        .REPEAT_RATE  (RRATE)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .kif   (kif)
    );

    // Physical keypad: pressed[c][r]=1 pulls row r low while column c is driven low.
    logic [3:0] pressed [0:3];
    logic [3:0] row_drv;

    always_comb begin
        row_drv = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            if (!kif.KEY_COL[c]) row_drv = row_drv & ~pressed[c];
        end
    end

    assign kif.KEY_ROW = row_drv;

    int         total      = 0;
    int         bad        = 0;
    int         valid_seen = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every KEY_VALID pops one expected code.
    always @(negedge CLK) begin
        if (kif.KEY_VALID === 1'b1) begin
            valid_seen++;
            check("valid_one_clk", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got code %0h expected no pulse at %0t",
                         kif.KEY_CODE, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code", {28'd0, kif.KEY_CODE}, {28'd0, mon_exp});
            end
        end
        prev_valid = kif.KEY_VALID;
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (kif.KEY_VALID !== 1'b1 && k < budget);
        check(name, {31'd0, kif.KEY_VALID}, 32'd1);
    endtask

    task automatic wait_held_low(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (kif.KEY_HELD !== 1'b0 && k < budget);
        check(name, {31'd0, kif.KEY_HELD}, 32'd0);
    endtask

    task automatic wait_col(input string name, input logic [3:0] want, input int budget);
        int k;
        k = 0;
        while (kif.KEY_COL !== want && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check(name, {28'd0, kif.KEY_COL}, {28'd0, want});
    endtask

    function automatic logic [3:0] ref_code(input int c, input logic [3:0] mask);
        int lr;
        lr = 0;
        for (int r = 3; r >= 0; r--) if (mask[r]) lr = r;
        return {2'(c), 2'(lr)};
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int         v0;
        int         h_ticks;
        int         pulses;
        int         c;
        logic [3:0] mask;
        logic [3:0] c0;

        for (int i = 0; i < 4; i++) pressed[i] = 4'b0000;

        // Reset values and idle column rotation.
        #2 RESET = 1'b1;
        clk_n(3);
        check("rst_col",   {28'd0, kif.KEY_COL},  32'he);
        check("rst_code",  {28'd0, kif.KEY_CODE}, 32'h0);
        check("rst_valid", {31'd0, kif.KEY_VALID}, 32'd0);
        check("rst_held",  {31'd0, kif.KEY_HELD},  32'd0);
        RESET = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge CLK);
            check("scan_col", {28'd0, kif.KEY_COL},
                  {28'd0, ~(4'b0001 << ((k / SCAN_DIV) % 4))});
        end

        // Clean press col2/row1, then release.
        pressed[2] = 4'b0010;
        exp_q.push_back(4'b1001);
        wait_valid("press_valid", 100);
        check("press_held", {31'd0, kif.KEY_HELD}, 32'd1);
        check("press_lock", {28'd0, kif.KEY_COL}, 32'hb);
        check("press_code", {28'd0, kif.KEY_CODE}, 32'h9);
        clk_n(1);
        check("press_pulse_end", {31'd0, kif.KEY_VALID}, 32'd0);
        pressed[2] = 4'b0000;
        clk_n(8);
        check("release_debounce", {31'd0, kif.KEY_HELD}, 32'd1);
        wait_held_low("release_held", 60);
        check("release_resume_col", {28'd0, kif.KEY_COL}, 32'h7);

        // Bounce on col0/row3: two matching ticks only.
        wait_col("bounce_wait_col0", 4'b1110, 40);
        pressed[0] = 4'b1000;
        clk_n(9);
        pressed[0] = 4'b0000;
        clk_n(24);
        check("bounce_code_kept", {28'd0, kif.KEY_CODE}, 32'h9);
        check("bounce_not_held", {31'd0, kif.KEY_HELD}, 32'd0);
        c0 = kif.KEY_COL;
        clk_n(SCAN_DIV);
        check("bounce_scan_moves", {28'd0, kif.KEY_COL}, {28'd0, c0[2:0], c0[3]});

        // Two keys in col1 -> lowest row; col3 press while held is ignored.
        pressed[1] = 4'b0101;
        exp_q.push_back(4'b0100);
        wait_valid("prio_valid", 100);
        check("prio_code", {28'd0, kif.KEY_CODE}, 32'h4);
        pressed[3] = 4'b0010;
        clk_n(60);
        check("lock_held", {31'd0, kif.KEY_HELD}, 32'd1);
        check("lock_col", {28'd0, kif.KEY_COL}, 32'hd);
        pressed[1] = 4'b0000;
        pressed[3] = 4'b0000;
        wait_held_low("lock_release", 60);
        clk_n(20);

        // Reset after two matching ticks, key kept down, accepted again from scratch.
        wait_col("rstdeb_wait_col0", 4'b1110, 40);
        pressed[0] = 4'b0001;
        clk_n(9);
        RESET = 1'b1;
        #1;
        check("rstdeb_col",   {28'd0, kif.KEY_COL},  32'he);
        check("rstdeb_code",  {28'd0, kif.KEY_CODE}, 32'h0);
        check("rstdeb_valid", {31'd0, kif.KEY_VALID}, 32'd0);
        check("rstdeb_held",  {31'd0, kif.KEY_HELD},  32'd0);
        clk_n(2);
        exp_q.push_back(4'b0000);
        RESET = 1'b0;
        clk_n(3 * SCAN_DIV - 1);
        check("rstdeb_not_yet", {31'd0, kif.KEY_VALID}, 32'd0);
        clk_n(1);
        check("rstdeb_valid_again", {31'd0, kif.KEY_VALID}, 32'd1);
        check("rstdeb_held_again",  {31'd0, kif.KEY_HELD},  32'd1);
        pressed[0] = 4'b0000;
        wait_held_low("rstdeb_release", 60);
        clk_n(8);

        // Randomized presses and short glitches.
        for (int it = 0; it < 16; it++) begin
            c = $urandom_range(3, 0);
            if ($urandom_range(9, 0) < 7) begin
                mask = 4'($urandom_range(15, 1));
                exp_q.push_back(ref_code(c, mask));
                pressed[c] = mask;
                wait_valid("rand_valid", 100);
                clk_n($urandom_range(8, 0));
                pressed[c] = 4'b0000;
                wait_held_low("rand_release", 60);
                clk_n($urandom_range(12, 4));
            end else begin
                pressed[c] = 4'($urandom_range(15, 1));
                clk_n($urandom_range(5, 1));
                pressed[c] = 4'b0000;
                clk_n(12);
                check("glitch_not_held", {31'd0, kif.KEY_HELD}, 32'd0);
            end
        end

        // Long hold col3/row3: pulse count follows from the number of held ticks.
        h_ticks = (37 + 2) / SCAN_DIV;
        pulses  = 1;
`ifdef KEYPAD_REPEAT_EN
        if (h_ticks >= RDLY) pulses = pulses + 1 + (h_ticks - RDLY) / RRATE;
`endif
        for (int p = 0; p < pulses; p++) exp_q.push_back(4'b1111);
        v0 = valid_seen;
        pressed[3] = 4'b1000;
        wait_valid("hold_valid", 100);
        check("hold_code", {28'd0, kif.KEY_CODE}, 32'hf);
        clk_n(37);
        pressed[3] = 4'b0000;
        wait_held_low("hold_release", 60);
        clk_n(40);
        check("hold_pulse_count", valid_seen - v0, pulses);
        check("hold_code_kept", {28'd0, kif.KEY_CODE}, 32'hf);

        clk_n(20);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
